robo_motor: RTL and testbench
=============================

ROBO_MOTOR -- requirements
Module: robo_motor

Interface
REQ-001 Parameter DIV_PASSO, default 4: clock cycles per motor step; legal range 2..255.
REQ-002 Parameter PASSOS_FRENTE, default 2: steps executed per forward command; legal range 1..255.
REQ-003 Parameter PASSOS_GIRO, default 3: steps executed per turn command; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 f  input  1  forward command from the wall-following controller.
REQ-007 g  input  1  turn command from the wall-following controller.
REQ-008 mot_e_en  output  1  left wheel enable.
REQ-009 mot_d_en  output  1  right wheel enable.
REQ-010 mot_e_dir  output  1  left wheel direction; 1 = forward.
REQ-011 mot_d_dir  output  1  right wheel direction; 1 = forward.
REQ-012 passo  output  1  step strobe, one clk cycle wide.
REQ-013 ocupado  output  1  busy; high while a movement is in progress.
REQ-014 erro  output  1  sticky flag for an illegal command.

Function
REQ-015 The block SHALL be a Moore FSM with states PARADO, FRENTE and GIRO, plus an 8-bit step divider and an 8-bit step counter.
REQ-016 In PARADO, {f,g}=10 at a rising edge SHALL enter FRENTE, clear the divider and load the step counter with PASSOS_FRENTE.
REQ-017 In PARADO, {f,g}=01 at a rising edge SHALL enter GIRO, clear the divider and load the step counter with PASSOS_GIRO.
REQ-018 In PARADO, {f,g}=00 SHALL keep the FSM in PARADO.
REQ-019 In PARADO, {f,g}=11 SHALL keep the FSM in PARADO and set erro at that edge.
REQ-020 In FRENTE or GIRO, the divider SHALL count 0..DIV_PASSO-1 and wrap to 0.
REQ-021 passo SHALL equal 1 exactly when the state is not PARADO and the divider equals DIV_PASSO-1.
REQ-022 At each edge where passo=1, the step counter SHALL decrement by 1.
REQ-023 At the edge where passo=1 and the step counter equals 1, the FSM SHALL return to PARADO.
REQ-024 Each command SHALL therefore occupy exactly N*DIV_PASSO cycles, where N is the loaded step count, and produce exactly N passo pulses, the last one in the final cycle.
REQ-025 While in FRENTE or GIRO, f and g SHALL be ignored; commands are not queued.
REQ-026 Once back in PARADO, the FSM SHALL spend at least one cycle there before accepting a new command, so a held f or g re-triggers after one idle cycle.
REQ-027 Outputs SHALL be decoded from the state register only, with no combinational path from f or g:
- PARADO: en=00, dir=00, ocupado=0.
- FRENTE: en=11, mot_e_dir=1, mot_d_dir=1, ocupado=1.
- GIRO: en=11, mot_e_dir=1, mot_d_dir=0 (pivot right), ocupado=1.
REQ-028 erro SHALL remain 1 until reset and SHALL NOT affect FSM operation.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for a clock edge, force: state PARADO, divider 0, step counter 0, erro 0, and all outputs 0.
REQ-030 Asserting rst in the middle of a movement SHALL abort it with no further passo pulse.
REQ-031 After rst is released, the first rising edge SHALL evaluate f and g as in PARADO.

Verification
REQ-032 Use default parameters for all scenarios below.
REQ-033 Forward: f=1, g=0 for one cycle -> ocupado=1 for 8 cycles, mot_e_dir=mot_d_dir=1, passo pulses in cycles 4 and 8, then PARADO.
REQ-034 Turn: g=1 for one cycle -> ocupado=1 for 12 cycles, dir=1/0, passo pulses in cycles 4, 8 and 12.
REQ-035 Illegal: {f,g}=11 in PARADO -> state stays PARADO, erro=1 and stays 1 through later legal commands until rst.
REQ-036 Ignore and re-trigger: f toggled during FRENTE has no effect; f held high continuously -> 8 busy cycles, 1 idle cycle, 8 busy cycles.
REQ-037 Reset mid-turn: rst asserted in cycle 6 of GIRO, between clock edges -> en, dir, passo and ocupado go to 0 at once; after release, g=0 and f=0 keep the FSM in PARADO.

Source files
------------

// File: rtl/robo_motor.sv
// Wheel driver for the wall-following robot: turns one-shot forward/turn
// commands into a fixed number of motor steps with a step strobe and busy flag.
module robo_motor #(
    parameter int unsigned DIV_PASSO     = 4,
    parameter int unsigned PASSOS_FRENTE = 2,
    parameter int unsigned PASSOS_GIRO   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic f,
    input  logic g,
    output logic mot_e_en,
    output logic mot_d_en,
    output logic mot_e_dir,
    output logic mot_d_dir,
    output logic passo,
    output logic ocupado,
    output logic erro
);

    typedef enum logic [1:0] {
        PARADO = 2'd0,
        FRENTE = 2'd1,
        GIRO   = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST    = 8'(DIV_PASSO - 1);
    localparam logic [7:0] LOAD_FRENTE = 8'(PASSOS_FRENTE);
    localparam logic [7:0] LOAD_GIRO   = 8'(PASSOS_GIRO);

    state_t     state;
    state_t     state_next;
    logic [7:0] div;
    logic [7:0] cnt;

    // State register; reset forces PARADO without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PARADO;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and Moore output decode (outputs depend on registers only).
    always_comb begin
        state_next = state;
        mot_e_en   = 1'b0;
        mot_d_en   = 1'b0;
        mot_e_dir  = 1'b0;
        mot_d_dir  = 1'b0;
        ocupado    = 1'b0;
        passo      = (state != PARADO) && (div == DIV_LAST);
        case (state)
            PARADO: begin
                if (f && !g) begin
                    state_next = FRENTE;
                end else if (!f && g) begin
                    state_next = GIRO;
                end
            end
            FRENTE: begin
                mot_e_en  = 1'b1;
                mot_d_en  = 1'b1;
                mot_e_dir = 1'b1;
                mot_d_dir = 1'b1;
                ocupado   = 1'b1;
                if (passo && cnt == 8'd1) begin
                    state_next = PARADO;
                end
            end
            GIRO: begin
                mot_e_en  = 1'b1;
                mot_d_en  = 1'b1;
                mot_e_dir = 1'b1;
                mot_d_dir = 1'b0;
                ocupado   = 1'b1;
                if (passo && cnt == 8'd1) begin
                    state_next = PARADO;
                end
            end
            default: begin
                state_next = PARADO;
            end
        endcase
    end

    // Step divider, remaining-step counter and sticky illegal-command flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div  <= '0;
            cnt  <= '0;
            erro <= 1'b0;
        end else if (state == PARADO) begin
            div <= '0;
            if (f && !g) begin
                cnt <= LOAD_FRENTE;
            end else if (!f && g) begin
                cnt <= LOAD_GIRO;
            end
            if (f && g) begin
                erro <= 1'b1;
            end
        end else begin
            if (passo) begin
                div <= '0;
                cnt <= cnt - 8'd1;
            end else begin
                div <= div + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_robo_motor.sv
// Directed self-checking bench for robo_motor with default parameters.
module tb_robo_motor;

    logic clk;
    logic rst;
    logic f;
    logic g;
    logic mot_e_en;
    logic mot_d_en;
    logic mot_e_dir;
    logic mot_d_dir;
    logic passo;
    logic ocupado;
    logic erro;

    int checks = 0;
    int errors = 0;

    robo_motor dut (
        .clk       (clk),
        .rst       (rst),
        .f         (f),
        .g         (g),
        .mot_e_en  (mot_e_en),
        .mot_d_en  (mot_d_en),
        .mot_e_dir (mot_e_dir),
        .mot_d_dir (mot_d_dir),
        .passo     (passo),
        .ocupado   (ocupado),
        .erro      (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {e_en, d_en, e_dir, d_dir, passo, ocupado, erro}.
    function automatic logic [6:0] obs();
        return {mot_e_en, mot_d_en, mot_e_dir, mot_d_dir, passo, ocupado, erro};
    endfunction

    // mode: 0 = idle, 1 = forward, 2 = turn.
    function automatic logic [6:0] expv(input int mode, input logic p, input logic e);
        case (mode)
            1:       return {4'b1111, p, 1'b1, e};
            2:       return {4'b1110, p, 1'b1, e};
            default: return {4'b0000, 1'b0, 1'b0, e};
        endcase
    endfunction

    task automatic check(input string tag, input logic [6:0] o, input logic [6:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        f   = 1'b0;
        g   = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_async", obs(), expv(0, 1'b0, 1'b0));
        tick();
        tick();
        @(negedge clk) rst = 1'b0;
        tick();
        check("after_reset_idle", obs(), expv(0, 1'b0, 1'b0));

        // Forward: one-cycle f pulse, 8 busy cycles, strobes in cycles 4 and 8.
        f = 1'b1;
        tick();
        f = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("fwd_c%0d", c), obs(), expv(1, (c % 4) == 0, 1'b0));
            tick();
        end
        check("fwd_done", obs(), expv(0, 1'b0, 1'b0));

        // Turn: 12 busy cycles, left forward / right reverse.
        g = 1'b1;
        tick();
        g = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("turn_c%0d", c), obs(), expv(2, (c % 4) == 0, 1'b0));
            tick();
        end
        check("turn_done", obs(), expv(0, 1'b0, 1'b0));

        // Illegal command: stays idle, erro latches and survives a legal command.
        f = 1'b1;
        g = 1'b1;
        tick();
        f = 1'b0;
        g = 1'b0;
        check("illegal_idle", obs(), expv(0, 1'b0, 1'b1));
        tick();
        check("illegal_hold", obs(), expv(0, 1'b0, 1'b1));
        f = 1'b1;
        tick();
        f = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("err_fwd_c%0d", c), obs(), expv(1, (c % 4) == 0, 1'b1));
            tick();
        end
        check("err_fwd_done", obs(), expv(0, 1'b0, 1'b1));

        // f/g toggling during a forward move is ignored and not queued.
        f = 1'b1;
        tick();
        f = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("ign_c%0d", c), obs(), expv(1, (c % 4) == 0, 1'b1));
            f = (c < 8) ? c[0] : 1'b0;
            g = (c == 3) ? 1'b1 : 1'b0;
            tick();
        end
        g = 1'b0;
        check("ign_done", obs(), expv(0, 1'b0, 1'b1));
        tick();
        check("ign_no_queue", obs(), expv(0, 1'b0, 1'b1));

        // Held f: 8 busy, 1 idle, 8 busy.
        f = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("held1_c%0d", c), obs(), expv(1, (c % 4) == 0, 1'b1));
            tick();
        end
        check("held_gap", obs(), expv(0, 1'b0, 1'b1));
        tick();
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("held2_c%0d", c), obs(), expv(1, (c % 4) == 0, 1'b1));
            if (c == 8) f = 1'b0;
            tick();
        end
        check("held_done", obs(), expv(0, 1'b0, 1'b1));

        // Reset mid-turn (cycle 6) between edges: everything drops at once.
        g = 1'b1;
        tick();
        g = 1'b0;
        for (int c = 1; c < 6; c++) begin
            tick();
        end
        check("turn_c6_pre_rst", obs(), expv(2, 1'b0, 1'b1));
        #2 rst = 1'b1;
        #1;
        check("rst_mid_turn", obs(), expv(0, 1'b0, 1'b0));
        tick();
        check("rst_held", obs(), expv(0, 1'b0, 1'b0));
        @(negedge clk) rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check($sformatf("post_rst_idle_%0d", c), obs(), expv(0, 1'b0, 1'b0));
        end

        // Fresh turn after reset proves the counter reloads cleanly.
        g = 1'b1;
        tick();
        g = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("turn2_c%0d", c), obs(), expv(2, (c % 4) == 0, 1'b0));
            tick();
        end
        check("turn2_done", obs(), expv(0, 1'b0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
